// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo : dual-write / dual-read instruction queue between fetch and
// decode.  Fetch can deliver up to two sequential instructions per cycle and
// the decode stage can consume up to two (master head + slave head+1).
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   flush               discard every queued entry (taken branch/jump)
//   push_valid_1/2      fetch slots; slot 2 only counts when slot 1 is valid
//   push_inst_1/2       instruction words for the two fetch slots
//   push_pc_1/2         PCs for the two fetch slots
//   pop_1, pop_2        consume head / head+1; pop_2 only counts with pop_1
//   inst_out_1, pc_out_1  head entry
//   inst_out_2, pc_out_2  head+1 entry
//   valid_out_1/2       head / head+1 entry occupied
//   full                fewer than two free entries
//   empty               no entries held
//   count               occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push_valid_1,
   input  logic [31:0]   push_inst_1,
   input  logic [31:0]   push_pc_1,
   input  logic          push_valid_2,
   input  logic [31:0]   push_inst_2,
   input  logic [31:0]   push_pc_2,
   input  logic          pop_1,
   input  logic          pop_2,
   output logic [31:0]   inst_out_1,
   output logic [31:0]   pc_out_1,
   output logic [31:0]   inst_out_2,
   output logic [31:0]   pc_out_2,
   output logic          valid_out_1,
   output logic          valid_out_2,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_LIMIT = (AW+1)'(DEPTH - 2);

   logic [31:0]   memPc   [DEPTH];
   logic [31:0]   memInst [DEPTH];

   logic [AW-1:0] rp;
   logic [AW-1:0] wp;
   logic [AW-1:0] rpPlus1;
   logic [AW-1:0] wpPlus1;
   logic [1:0]    nPop;
   logic [1:0]    nPush;
   logic [AW:0]   countNext;

   assign rpPlus1 = rp + AW'(1);
   assign wpPlus1 = wp + AW'(1);

   // Status flags, all derived from the registered occupancy.
   assign full        = (count > FULL_LIMIT);
   assign empty       = (count == '0);
   assign valid_out_1 = (count >= (AW+1)'(1));
   assign valid_out_2 = (count >= (AW+1)'(2));

   // Read ports come straight from storage; a same-cycle push is never
   // forwarded to the outputs.
   assign pc_out_1   = memPc[rp];
   assign inst_out_1 = memInst[rp];
   assign pc_out_2   = memPc[rpPlus1];
   assign inst_out_2 = memInst[rpPlus1];

   // Effective pop count, clipped to what is actually held.
   always_comb begin
      nPop = 2'd0;
      if (pop_1) begin
         if (pop_2 && (count >= (AW+1)'(2))) begin
            nPop = 2'd2;
         end else if (count >= (AW+1)'(1)) begin
            nPop = 2'd1;
         end
      end
   end

   // Effective push count. Full is judged before this cycle's pops, so a
   // pop never opens room for a same-cycle push while full.
   always_comb begin
      nPush = 2'd0;
      if (!full && push_valid_1) begin
         nPush = push_valid_2 ? 2'd2 : 2'd1;
      end
   end

   assign countNext = count + (AW+1)'(nPush) - (AW+1)'(nPop);

   // Pointer and occupancy state.
   always_ff @(posedge clk) begin
      if (rst) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else if (flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         rp    <= rp + AW'(nPop);
         wp    <= wp + AW'(nPush);
         count <= countNext;
      end
   end

   // Storage is never cleared; writes are suppressed while reset or flush
   // is active so discarded pushes leave the array untouched.
   always_ff @(posedge clk) begin
      if (!rst && !flush && (nPush != 2'd0)) begin
         memPc[wp]   <= push_pc_1;
         memInst[wp] <= push_inst_1;
         if (nPush == 2'd2) begin
            memPc[wpPlus1]   <= push_pc_2;
            memInst[wpPlus1] <= push_inst_2;
         end
      end
   end

endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic          push_valid_1, push_valid_2;
   logic [31:0]   push_inst_1, push_pc_1, push_inst_2, push_pc_2;
   logic          pop_1, pop_2;
   logic [31:0]   inst_out_1, pc_out_1, inst_out_2, pc_out_2;
   logic          valid_out_1, valid_out_2, full, empty;
   logic [AW:0]   count;

   int unsigned   nVec  = 0;
   int unsigned   nFail = 0;
   logic          checkEn = 1'b0;
   logic [31:0]   nextPc = 32'h0;

   // Reference queue: each entry is {pc, inst}, head at index 0.
   logic [63:0]   refQ[$];

   inst_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid_1(push_valid_1), .push_inst_1(push_inst_1), .push_pc_1(push_pc_1),
      .push_valid_2(push_valid_2), .push_inst_2(push_inst_2), .push_pc_2(push_pc_2),
      .pop_1(pop_1), .pop_2(pop_2),
      .inst_out_1(inst_out_1), .pc_out_1(pc_out_1),
      .inst_out_2(inst_out_2), .pc_out_2(pc_out_2),
      .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
      .full(full), .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instOf(input logic [31:0] pc);
      return 32'h2000_0000 ^ (pc << 4) ^ 32'h0000_0005;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update from the queue-level rules, applied at each rising edge.
   task automatic modelStep();
      int nPo, nPu;
      bit isFull;
      if (rst || flush) begin
         refQ.delete();
         return;
      end
      isFull = (refQ.size() > DEPTH - 2);
      nPo = !pop_1 ? 0 : (pop_2 ? 2 : 1);
      if (nPo > refQ.size()) nPo = refQ.size();
      nPu = (isFull || !push_valid_1) ? 0 : (push_valid_2 ? 2 : 1);
      for (int i = 0; i < nPo; i++) void'(refQ.pop_front());
      if (nPu >= 1) refQ.push_back({push_pc_1, push_inst_1});
      if (nPu == 2) refQ.push_back({push_pc_2, push_inst_2});
   endtask

   // Single compare process: every negedge once enabled.
   always @(negedge clk) begin
      if (checkEn) begin
         check("count",  64'(count), 64'(refQ.size()));
         check("empty",  64'(empty), 64'(refQ.size() == 0));
         check("full",   64'(full),  64'(refQ.size() > DEPTH - 2));
         check("valid1", 64'(valid_out_1), 64'(refQ.size() >= 1));
         check("valid2", 64'(valid_out_2), 64'(refQ.size() >= 2));
         if (refQ.size() >= 1) check("head", {pc_out_1, inst_out_1}, refQ[0]);
         if (refQ.size() >= 2) check("head1", {pc_out_2, inst_out_2}, refQ[1]);
      end
   end

   // One clock: inputs already set, edge, model update, back to negedge.
   task automatic cycle();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      push_valid_1 = 1'b0; push_valid_2 = 1'b0;
      pop_1 = 1'b0; pop_2 = 1'b0;
   endtask

   // Push n (0..2) sequential PCs with the given pops, then clock once.
   task automatic op(input int n, input logic p1, input logic p2);
      push_pc_1 = nextPc;       push_inst_1 = instOf(nextPc);
      push_pc_2 = nextPc + 4;   push_inst_2 = instOf(nextPc + 4);
      push_valid_1 = (n >= 1);
      push_valid_2 = (n == 2);
      pop_1 = p1; pop_2 = p2;
      if (!full) nextPc = nextPc + 32'(4 * n);
      cycle();
   endtask

   task automatic doReset();
      rst = 1'b1;
      cycle();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      push_valid_1 = 1'b0; push_valid_2 = 1'b0;
      push_inst_1 = '0; push_pc_1 = '0; push_inst_2 = '0; push_pc_2 = '0;
      pop_1 = 1'b0; pop_2 = 1'b0;
      @(negedge clk);
      cycle();
      checkEn = 1'b1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full",  64'(full),  64'd0);
      check("rst_valid", 64'({valid_out_1, valid_out_2}), 64'd0);

      // First dual push with explicit values.
      push_valid_1 = 1'b1; push_pc_1 = 32'h0; push_inst_1 = 32'h2001_0005;
      push_valid_2 = 1'b1; push_pc_2 = 32'h4; push_inst_2 = 32'h2002_0007;
      cycle();
      check("first_count", 64'(count), 64'd2);
      check("first_valid", 64'({valid_out_1, valid_out_2}), 64'b11);
      check("first_pc1",   64'(pc_out_1), 64'h0);
      check("first_inst2", 64'(inst_out_2), 64'h2002_0007);

      // Fill two per cycle from empty; pushes while full are dropped.
      doReset(); nextPc = 32'h1000;
      for (int i = 0; i < 8; i++) op(2, 1'b0, 1'b0);
      check("fill_count", 64'(count), 64'd16);
      check("fill_full",  64'(full),  64'd1);
      op(2, 1'b0, 1'b0);
      check("over_count", 64'(count), 64'd16);
      op(2, 1'b1, 1'b1);
      check("fullpop_count", 64'(count), 64'd14);
      check("fullpop_head",  64'(pc_out_1), 64'h1008);
      doReset(); nextPc = 32'h1100;
      op(1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) op(2, 1'b0, 1'b0);
      check("f15_count", 64'(count), 64'd15);
      check("f15_full",  64'(full),  64'd1);
      op(1, 1'b0, 1'b0);
      check("f15_hold",  64'(count), 64'd15);

      // count 3, pop two and push two together.
      doReset(); nextPc = 32'h2000;
      op(2, 1'b0, 1'b0);
      op(1, 1'b0, 1'b0);
      op(2, 1'b1, 1'b1);
      check("pp_count", 64'(count), 64'd3);
      check("pp_head",  64'(pc_out_1), 64'h2008);
      check("pp_head1", 64'(pc_out_2), 64'h200c);

      // Pop clipping and lone pop_2.
      doReset(); nextPc = 32'h3000;
      op(1, 1'b0, 1'b0);
      op(0, 1'b1, 1'b1);
      check("clip_count", 64'(count), 64'd0);
      check("clip_empty", 64'(empty), 64'd1);
      op(0, 1'b1, 1'b0);
      check("pop_empty", 64'(count), 64'd0);
      op(2, 1'b0, 1'b0); op(2, 1'b0, 1'b0); op(1, 1'b0, 1'b0);
      op(0, 1'b0, 1'b1);
      check("pop2only", 64'(count), 64'd5);
      check("pop2only_head", 64'(pc_out_1), 64'h3004);

      // Flush beats a same-cycle push.
      doReset(); nextPc = 32'h4000;
      for (int i = 0; i < 5; i++) op(2, 1'b0, 1'b0);
      check("pre_flush", 64'(count), 64'd10);
      flush = 1'b1;
      op(2, 1'b1, 1'b0);
      check("flush_count", 64'(count), 64'd0);
      check("flush_empty", 64'(empty), 64'd1);
      nextPc = 32'h0040_0100;
      op(1, 1'b0, 1'b0);
      check("post_flush_pc", 64'(pc_out_1), 64'h0040_0100);

      // Wrap: rp moved to 15, then two entries straddle the array end.
      doReset(); nextPc = 32'h5000;
      for (int i = 0; i < 15; i++) op(1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) op(0, 1'b1, 1'b0);
      check("wrap_empty", 64'(empty), 64'd1);
      nextPc = 32'h100;
      op(2, 1'b0, 1'b0);
      check("wrap_pc1", 64'(pc_out_1), 64'h100);
      check("wrap_pc2", 64'(pc_out_2), 64'h104);
      rst = 1'b1;
      op(2, 1'b1, 1'b0);
      check("wrap_rst", 64'(count), 64'd0);

      // Directed mixed traffic across wrap points.
      nextPc = 32'h6000;
      for (int i = 0; i < 60; i++) begin
         if (i == 37) flush = 1'b1;
         op(i % 3, ((i / 2) % 3) != 0, (i % 4) == 1);
      end

      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
